// File: rtl/anita4_scaler_sequencer.sv
// anita4_scaler_sequencer
//   Counts rising edges on the ANITA4 trigger-map scaler lines over a fixed
//   gate period. At gate expiry it snapshots every count, clears the live
//   counters and sends the snapshot out one channel per word over a
//   valid/ready handshake.
//
//   Build option: define SCALER_MASK_EN to add the mask_i port. A masked
//   channel never counts, but it is still read out as 0, so every dump is
//   NCH words long.
//
// Ports
//   clk_i         system clock; all inputs are synchronous to it
//   rst_i         asynchronous active-high reset
//   enable_i      1 = gate timer and counters run
//   scaler_i      NCH scaler lines; bit0 = top_rcp[0]
//   mask_i        (SCALER_MASK_EN only) 1 = channel masked
//   dout_o        snapshot count of channel dindex_o
//   dindex_o      channel index of dout_o
//   dvalid_o      dout_o/dindex_o valid
//   dready_i      consumer accepts when dvalid_o & dready_i
//   dlast_o       final channel of a dump
//   overrun_o     sticky: a gate expired while a dump was in progress
//   overrun_clr_i synchronous clear of overrun_o (a new overrun wins)
module anita4_scaler_sequencer #(
    parameter int NCH       = 12,
    parameter int CNT_WIDTH = 16,
    parameter int PERIOD    = 1000000,
    parameter int PER_WIDTH = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [NCH-1:0]       scaler_i,
`ifdef SCALER_MASK_EN
    input  logic [NCH-1:0]       mask_i,
`endif
    output logic [CNT_WIDTH-1:0] dout_o,
    output logic [3:0]           dindex_o,
    output logic                 dvalid_o,
    input  logic                 dready_i,
    output logic                 dlast_o,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i
);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t               state_q, state_nx;
    logic [3:0]           ptr_q, ptr_nx, ptr_inc;
    logic [NCH-1:0]       prev_q, edge_v, active_v, mask_v;
    logic [CNT_WIDTH-1:0] cnt_q   [NCH];
    logic [CNT_WIDTH-1:0] cnt_inc [NCH];
    logic [CNT_WIDTH-1:0] snap_q  [NCH];
    logic [PER_WIDTH-1:0] timer_q;
    logic                 expiry;
    logic [CNT_WIDTH-1:0] dout_nx;
    logic [3:0]           dindex_nx;
    logic                 dvalid_nx, dlast_nx;

`ifdef SCALER_MASK_EN
    assign mask_v = mask_i;
`else
    assign mask_v = '0;
`endif

    // A channel counts only while the block is enabled and the channel is unmasked.
    assign active_v = enable_i ? ~mask_v : '0;
    assign edge_v   = scaler_i & ~prev_q & active_v;
    assign expiry   = enable_i && (timer_q == PER_WIDTH'(PERIOD - 1));
    assign ptr_inc  = ptr_q + 4'd1;

    // Next count including this cycle's edge. An inactive channel reports 0,
    // so a freshly masked channel drops its accrued count at once.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_inc[i] = '0;
            if (active_v[i]) begin
                cnt_inc[i] = (cnt_q[i] == '1) ? cnt_q[i]
                                              : cnt_q[i] + CNT_WIDTH'(edge_v[i]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            timer_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            prev_q <= scaler_i;
            if (!enable_i || expiry) timer_q <= '0;
            else                     timer_q <= timer_q + 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (expiry) cnt_q[i] <= '0;
                else        cnt_q[i] <= cnt_inc[i];
                if (expiry && state_q == IDLE) snap_q[i] <= cnt_inc[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          overrun_o <= 1'b0;
        else if (expiry && state_q == DUMP) overrun_o <= 1'b1;
        else if (overrun_clr_i)             overrun_o <= 1'b0;
    end

    // The output word is registered. On expiry, word 0 is loaded straight from
    // cnt_inc, because snap_q is written on that same edge.
    always_comb begin
        state_nx  = state_q;
        ptr_nx    = ptr_q;
        dvalid_nx = dvalid_o;
        dout_nx   = dout_o;
        dindex_nx = dindex_o;
        dlast_nx  = dlast_o;
        case (state_q)
            IDLE: begin
                if (expiry) begin
                    state_nx  = DUMP;
                    ptr_nx    = '0;
                    dvalid_nx = 1'b1;
                    dout_nx   = cnt_inc[0];
                    dindex_nx = '0;
                    dlast_nx  = (NCH == 1);
                end
            end
            DUMP: begin
                if (dready_i) begin
                    if (ptr_q == 4'(NCH - 1)) begin
                        state_nx  = IDLE;
                        ptr_nx    = '0;
                        dvalid_nx = 1'b0;
                        dout_nx   = '0;
                        dindex_nx = '0;
                        dlast_nx  = 1'b0;
                    end else begin
                        ptr_nx    = ptr_inc;
                        dout_nx   = snap_q[ptr_inc];
                        dindex_nx = ptr_inc;
                        dlast_nx  = (ptr_inc == 4'(NCH - 1));
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            dvalid_o <= 1'b0;
            dout_o   <= '0;
            dindex_o <= '0;
            dlast_o  <= 1'b0;
        end else begin
            state_q  <= state_nx;
            ptr_q    <= ptr_nx;
            dvalid_o <= dvalid_nx;
            dout_o   <= dout_nx;
            dindex_o <= dindex_nx;
            dlast_o  <= dlast_nx;
        end
    end

endmodule

// File: tb/tb_anita4_scaler_sequencer.sv
// tb_anita4_scaler_sequencer
//   Directed bench for anita4_scaler_sequencer with PERIOD=32 and CNT_WIDTH=4,
//   so a run of 16 edges saturates the counter. A table of gate scenarios
//   gives pulse counts and the counts each dump must report. Hand-written
//   sequences cover an edge in the expiry cycle, a stalled dump with
//   overrun, and a reset in the middle of a dump.
module tb_anita4_scaler_sequencer;

    localparam int NCH    = 12;
    localparam int CW     = 4;
    localparam int PERIOD = 32;
    localparam int PW     = 5;

    typedef logic [CW-1:0] exp_arr_t [NCH];

    typedef struct {
        int ca;
        int na;
        int cb;
        int nb;
        bit hold_b;
        int exp_a;
        int exp_b;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NCH-1:0] scaler;
    logic [NCH-1:0] mask;
    logic [CW-1:0] dout;
    logic [3:0]    dindex;
    logic          dvalid;
    logic          dready;
    logic          dlast;
    logic          overrun;
    logic          overrun_clr;

    int tests = 0;
    int fails = 0;

    anita4_scaler_sequencer #(
        .NCH(NCH), .CNT_WIDTH(CW), .PERIOD(PERIOD), .PER_WIDTH(PW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .scaler_i(scaler),
`ifdef SCALER_MASK_EN
        .mask_i(mask),
`endif
        .dout_o(dout),
        .dindex_o(dindex),
        .dvalid_o(dvalid),
        .dready_i(dready),
        .dlast_o(dlast),
        .overrun_o(overrun),
        .overrun_clr_i(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full gate from an idle, disabled start. Channel a gets na one-cycle
    // pulses. Channel b gets nb pulses, or is held high for the whole gate.
    task automatic run_gate(input int ca, input int na, input int cb, input int nb,
                            input bit hold_b, input bit keep_en);
        enable = 1'b1;
        for (int k = 0; k < PERIOD; k++) begin
            scaler = '0;
            if (k % 2 == 0 && k / 2 < na) scaler[ca] = 1'b1;
            if (hold_b) scaler[cb] = 1'b1;
            else if (k % 2 == 0 && k / 2 < nb) scaler[cb] = 1'b1;
            tick();
        end
        scaler = '0;
        if (!keep_en) enable = 1'b0;
    endtask

    task automatic read_dump(input string tag, input exp_arr_t exp);
        dready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            tests++;
            if (!(dvalid === 1'b1 && dindex === 4'(i) && dout === exp[i] &&
                  dlast === (i == NCH - 1))) begin
                fails++;
                $display("FAIL %s word%0d: valid=%0b idx=%0d data=%0d last=%0b, expected valid=1 idx=%0d data=%0d last=%0b",
                         tag, i, dvalid, dindex, dout, dlast, i, exp[i], (i == NCH - 1));
            end
            tick();
        end
        check({tag, " valid after last"}, int'(dvalid), 0);
    endtask

    function automatic exp_arr_t zero_exp();
        exp_arr_t e;
        for (int i = 0; i < NCH; i++) e[i] = '0;
        return e;
    endfunction

    vec_t     vecs [5];
    exp_arr_t exp;
    int       n;
    bit       ok;

    initial begin
        vecs[0] = '{ca: 0,  na: 5, cb: 11, nb: 3,  hold_b: 1'b0, exp_a: 5, exp_b: 3};
        vecs[1] = '{ca: 2,  na: 1, cb: 4,  nb: 0,  hold_b: 1'b1, exp_a: 1, exp_b: 1};
        vecs[2] = '{ca: 7,  na: 9, cb: 4,  nb: 16, hold_b: 1'b0, exp_a: 9, exp_b: 15};
        vecs[3] = '{ca: 10, na: 0, cb: 1,  nb: 15, hold_b: 1'b0, exp_a: 0, exp_b: 15};
        vecs[4] = '{ca: 3,  na: 2, cb: 9,  nb: 14, hold_b: 1'b0, exp_a: 2, exp_b: 14};

        rst = 1'b1; enable = 1'b0; scaler = '0; mask = '0;
        dready = 1'b1; overrun_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset dvalid",  int'(dvalid),  0);
        check("reset dout",    int'(dout),    0);
        check("reset dindex",  int'(dindex),  0);
        check("reset dlast",   int'(dlast),   0);
        check("reset overrun", int'(overrun), 0);

        for (int v = 0; v < 5; v++) begin
            run_gate(vecs[v].ca, vecs[v].na, vecs[v].cb, vecs[v].nb, vecs[v].hold_b, 1'b0);
            exp = zero_exp();
            exp[vecs[v].ca] = CW'(vecs[v].exp_a);
            exp[vecs[v].cb] = CW'(vecs[v].exp_b);
            read_dump($sformatf("vec%0d", v), exp);
        end

        // An edge in the expiry cycle closes into that gate, not the next one.
        enable = 1'b1;
        for (int k = 0; k < PERIOD; k++) begin
            scaler = (k == PERIOD - 1) ? 12'h004 : 12'h000;
            tick();
        end
        scaler = '0;
        exp = zero_exp();
        exp[2] = 4'd1;
        read_dump("expiry edge", exp);
        n = 0;
        while (!dvalid && n < 100) begin
            tick();
            n++;
        end
        check("expiry edge next dump arrives", int'(dvalid), 1);
        read_dump("expiry edge next gate", zero_exp());
        enable = 1'b0;
        tick();

        // Stalled dump: word 0 holds while a second gate expires and overruns.
        dready = 1'b0;
        run_gate(0, 5, 1, 0, 1'b0, 1'b1);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!(dvalid === 1'b1 && dindex === 4'd0 && dout === 4'd5 && dlast === 1'b0))
                ok = 1'b0;
            tick();
        end
        check("stall word0 stable", int'(ok), 1);
        check("overrun set", int'(overrun), 1);
        enable = 1'b0;
        exp = zero_exp();
        exp[0] = 4'd5;
        read_dump("overrun dump", exp);
        check("overrun sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun cleared", int'(overrun), 0);

        // Reset with word 5 on the bus.
        dready = 1'b1;
        run_gate(0, 5, 11, 3, 1'b0, 1'b0);
        repeat (5) tick();
        check("pre-reset index", int'(dindex), 5);
        rst = 1'b1;
        #1;
        check("mid reset dvalid", int'(dvalid), 0);
        check("mid reset dout",   int'(dout),   0);
        check("mid reset dindex", int'(dindex), 0);
        check("mid reset dlast",  int'(dlast),  0);
        tick();
        rst = 1'b0;
        tick();
        check("post reset idle", int'(dvalid), 0);
        run_gate(0, 3, 1, 2, 1'b0, 1'b0);
        exp = zero_exp();
        exp[0] = 4'd3;
        exp[1] = 4'd2;
        read_dump("after reset", exp);

`ifdef SCALER_MASK_EN
        mask = 12'h001;
        run_gate(0, 5, 1, 4, 1'b0, 1'b0);
        exp = zero_exp();
        exp[1] = 4'd4;
        read_dump("masked", exp);
        mask = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
